// File: rtl/divu_share_ctrl_pkg.sv
// Shared types and constants for the time-shared 256-bit divider front end.
// State codes, default width and the response bundle layout.
package divu_share_pkg;

  localparam int W_DEF   = 256;
  localparam int IDW_MAX = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_REST  = 3'd4;

  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [W_DEF-1:0]   val;
    logic [W_DEF-1:0]   rem;
    logic               dbz;
    logic               err;
  } rsp_t;

  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/divu_share_ctrl_if.sv
// Requester-side request/response bundle for divu_share_ctrl.
// master = requesters, slave = the sharing controller.
interface divu_share_if #(
  parameter int NREQ = 4,
  parameter int W    = 256
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_divd;
  logic [NREQ*W-1:0] req_dvsr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_val;
  logic [W-1:0]      rsp_rem;
  logic              rsp_dbz;
  logic              rsp_err;

  modport master (
    output req_valid, req_divd, req_dvsr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_val,
    input  rsp_rem, rsp_dbz, rsp_err
  );

  modport slave (
    input  req_valid, req_divd, req_dvsr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_val,
    output rsp_rem, rsp_dbz, rsp_err
  );

endinterface

// File: rtl/divu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
// Emits both a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/divu_share_ctrl.sv
// Shares one iterative divider among NREQ requesters with round-robin
// arbitration and a launch-to-ready watchdog.
module divu_share_ctrl
  import divu_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 320
) (
  input  logic         clk,
  input  logic         rst,
  divu_share_if.slave  bus,
  output logic         div_go,
  output logic [W-1:0] div_divd,
  output logic [W-1:0] div_dvsr,
  input  logic [W-1:0] div_val,
  input  logic [W-1:0] div_rem,
  input  logic         div_dbz,
  input  logic         div_rdy,
  output logic         busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [2:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [WDW-1:0]  wdog;

  logic [IDW-1:0]  id_q;
  logic [W-1:0]    val_q;
  logic [W-1:0]    rem_q;
  logic            dbz_q;
  logic            err_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign bus.req_ready = (state == S_GRANT) ? gnt_oh : '0;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_val   = val_q;
  assign bus.rsp_rem   = rem_q;
  assign bus.rsp_dbz   = dbz_q;
  assign bus.rsp_err   = err_q;

  // Divider stays enabled through RESP so it keeps presenting its result.
  assign div_go = (state == S_RUN) || (state == S_RESP);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_oh   <= '0;
      wdog     <= '0;
      div_divd <= '0;
      div_dvsr <= '0;
      id_q     <= '0;
      val_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_gnt;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          div_divd <= bus.req_divd[int'(gnt_idx)*W +: W];
          div_dvsr <= bus.req_dvsr[int'(gnt_idx)*W +: W];
          id_q     <= gnt_idx;
          ptr      <= IDW'(wrap_inc(int'(gnt_idx), NREQ));
          wdog     <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (div_rdy) begin
            val_q <= div_val;
            rem_q <= div_rem;
            dbz_q <= div_dbz;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            val_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (wdog != {WDW{1'b1}}) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_REST;
        end
        S_REST: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Winner must hold valid through its grant cycle.
  a_hold_valid: assert property (
    @(posedge clk) disable iff (!rst)
    (state == S_GRANT) |-> bus.req_valid[gnt_idx]
  );

endmodule

// File: tb/tb_divu_share_ctrl.sv
// Directed bench for divu_share_ctrl with a behavioural divider model.
// Vector table plus hand-written sequences for timeout, stall and reset.
module tb_divu_share_ctrl;
  import divu_share_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 256;
  localparam int TO   = 320;
  localparam int LAT  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         div_go;
  logic [W-1:0] div_divd;
  logic [W-1:0] div_dvsr;
  logic [W-1:0] div_val;
  logic [W-1:0] div_rem;
  logic         div_dbz;
  logic         div_rdy;
  logic         busy;

  int checks = 0;
  int errors = 0;

  divu_share_if #(.NREQ(NREQ), .W(W)) bus ();

  divu_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .div_go   (div_go),
    .div_divd (div_divd),
    .div_dvsr (div_dvsr),
    .div_val  (div_val),
    .div_rem  (div_rem),
    .div_dbz  (div_dbz),
    .div_rdy  (div_rdy),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural divider: cleared while div_go low, result after LAT cycles.
  logic         hang = 1'b0;
  logic [W-1:0] m_val;
  logic [W-1:0] m_rem;
  logic         m_dbz;
  logic         m_rdy;
  int           m_cnt;

  always @(posedge clk) begin
    if (!div_go) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
      m_val <= '0;
      m_rem <= '0;
      m_dbz <= 1'b0;
    end else if (!hang && !m_rdy) begin
      if (m_cnt == LAT - 1) begin
        m_rdy <= 1'b1;
        if (div_dvsr == '0) begin
          m_val <= '1;
          m_rem <= div_divd;
          m_dbz <= 1'b1;
        end else begin
          m_val <= div_divd / div_dvsr;
          m_rem <= div_divd % div_dvsr;
          m_dbz <= 1'b0;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign div_val = hang ? W'(256'hdead) : m_val;
  assign div_rem = hang ? W'(256'hbeef) : m_rem;
  assign div_dbz = hang ? 1'b1 : m_dbz;
  assign div_rdy = hang ? 1'b0 : m_rdy;

  logic [NREQ-1:0] pend = '0;
  int gq[$];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~pend;
    pend = bus.req_ready;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) gq.push_back(i);
  endtask

  task automatic issue(int id, logic [W-1:0] dd, logic [W-1:0] dv);
    bus.req_divd[id*W +: W] = dd;
    bus.req_dvsr[id*W +: W] = dv;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(output rsp_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      step();
      if (bus.rsp_valid) begin
        ok    = 1'b1;
        r.id  = {1'b0, bus.rsp_id};
        r.val = bus.rsp_val;
        r.rem = bus.rsp_rem;
        r.dbz = bus.rsp_dbz;
        r.err = bus.rsp_err;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got none expected rsp_valid");
    end
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    pend = '0;
    step();
    step();
    rst = 1'b1;
    gq.delete();
  endtask

  task automatic chk_rsp(string nm, rsp_t r, rsp_t e);
    chk({nm, "_id"},  W'(r.id), W'(e.id));
    chk({nm, "_val"}, r.val, e.val);
    chk({nm, "_rem"}, r.rem, e.rem);
    chk({nm, "_dbz"}, W'(r.dbz), W'(e.dbz));
    chk({nm, "_err"}, W'(r.err), W'(e.err));
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] divd;
    logic [W-1:0] dvsr;
    rsp_t         exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    rsp_t r;
    rsp_t e;
    rsp_t first;
    bit   ok;
    bit   stable;
    int   cnt;

    vt[0].id = 0; vt[0].divd = W'(12);   vt[0].dvsr = W'(5);
    vt[0].exp = '{id: 0, val: W'(2), rem: W'(2), dbz: 0, err: 0};
    vt[1].id = 2; vt[1].divd = '1;       vt[1].dvsr = '1;
    vt[1].exp = '{id: 2, val: W'(1), rem: '0, dbz: 0, err: 0};
    vt[2].id = 2; vt[2].divd = W'(5);    vt[2].dvsr = W'(7);
    vt[2].exp = '{id: 2, val: '0, rem: W'(5), dbz: 0, err: 0};
    vt[3].id = 1; vt[3].divd = W'(100);  vt[3].dvsr = '0;
    vt[3].exp = '{id: 1, val: '1, rem: W'(100), dbz: 1, err: 0};
    vt[4].id = 3; vt[4].divd = W'(1000); vt[4].dvsr = W'(7);
    vt[4].exp = '{id: 3, val: W'(142), rem: W'(6), dbz: 0, err: 0};

    bus.req_valid = '0;
    bus.req_divd  = '0;
    bus.req_dvsr  = '0;
    bus.rsp_ready = 1'b0;
    do_reset();

    chk("rst_busy", W'(busy), '0);
    chk("rst_div_go", W'(div_go), '0);
    chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
    chk("rst_req_ready", W'(bus.req_ready), '0);
    chk("rst_div_divd", div_divd, '0);

    foreach (vt[i]) begin
      issue(vt[i].id, vt[i].divd, vt[i].dvsr);
      wait_rsp(r, ok);
      if (ok) chk_rsp($sformatf("vec%0d", i), r, vt[i].exp);
      ack();
      chk($sformatf("vec%0d_rest_go", i), W'(div_go), '0);
      chk($sformatf("vec%0d_rest_busy", i), W'(busy), W'(1));
    end

    do_reset();
    for (int i = 0; i < NREQ; i++) issue(i, W'(45), W'(9));
    for (int i = 0; i < NREQ; i++) begin
      wait_rsp(r, ok);
      e = '{id: IDW_MAX'(i), val: W'(5), rem: '0, dbz: 0, err: 0};
      if (ok) chk_rsp($sformatf("rr%0d", i), r, e);
      ack();
    end
    chk("rr_grants", W'(gq.size()), W'(4));
    for (int i = 0; i < gq.size(); i++)
      chk($sformatf("rr_order%0d", i), W'(gq[i]), W'(i));
    issue(3, W'(45), W'(9));
    wait_rsp(r, ok);
    if (ok) chk("wrap_id", W'(r.id), W'(3));
    ack();

    hang = 1'b1;
    issue(0, W'(77), W'(3));
    cnt = 0;
    while (!div_go && cnt < 100) begin
      step();
      cnt++;
    end
    chk("to_go_seen", W'(div_go), W'(1));
    cnt = 0;
    while (!bus.rsp_valid && cnt < 1000) begin
      step();
      cnt++;
    end
    chk("to_cycles", W'(cnt), W'(TO));
    chk("to_err", W'(bus.rsp_err), W'(1));
    chk("to_val", bus.rsp_val, '0);
    chk("to_rem", bus.rsp_rem, '0);
    chk("to_dbz", W'(bus.rsp_dbz), '0);
    ack();
    hang = 1'b0;

    issue(2, W'(81), W'(4));
    wait_rsp(first, ok);
    issue(1, W'(9), W'(3));
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (!bus.rsp_valid || bus.req_ready != '0 ||
          bus.rsp_val != first.val || bus.rsp_rem != first.rem ||
          {1'b0, bus.rsp_id} != first.id)
        stable = 1'b0;
    end
    chk("stall_stable", W'(stable), W'(1));
    chk("stall_val", first.val, W'(20));
    chk("stall_rem", first.rem, W'(1));
    ack();
    wait_rsp(r, ok);
    if (ok) chk("after_stall_id", W'(r.id), W'(1));
    if (ok) chk("after_stall_val", r.val, W'(3));
    ack();

    issue(0, W'(50), W'(5));
    cnt = 0;
    while (!div_go && cnt < 100) begin
      step();
      cnt++;
    end
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_go", W'(div_go), '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_rsp_valid", W'(bus.rsp_valid), '0);
    chk("mid_rst_divd", div_divd, '0);
    chk("mid_rst_rsp_val", bus.rsp_val, '0);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rsp_valid || busy) stable = 1'b0;
    end
    chk("mid_rst_quiet", W'(stable), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
